mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Sits directly downstream of the data-cache wrapper and the instruction-cache wrapper.
- Merges their two memory-side request ports (read + write channels, line-width data) onto the single memory port.
- Serves one transaction at a time, holds the grant until the memory's valid pulse, and routes the response back to the granted master only.

Parameters:
ADDR_WIDTH, 64, address width of all ports
DATA_WIDTH, 128, memory line width (2x CPU word)
MASK_WIDTH, DATA_WIDTH/8, byte-mask width

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
m{0,1}_raddr  in  ADDR_WIDTH  master read address (m0 = dcache, m1 = icache)
m{0,1}_ren  in  1  read request, held until m*_rvalid
m{0,1}_rvalid  out  1  read done pulse
m{0,1}_rdata  out  DATA_WIDTH  read data, valid with m*_rvalid
m{0,1}_waddr  in  ADDR_WIDTH  write address
m{0,1}_wen  in  1  write request, held until m*_wvalid
m{0,1}_wdata  in  DATA_WIDTH  write data
m{0,1}_wmask  in  MASK_WIDTH  byte mask
m{0,1}_wvalid  out  1  write done pulse
s_raddr/s_ren/s_waddr/s_wen/s_wdata/s_wmask  out  as above  memory-side request
s_rvalid/s_rdata/s_wvalid  in  as above  memory-side response

Behaviour:
- States: IDLE, GRANT.
- Registered grant fields: gnt_m (master 0/1), gnt_w (1 = write, 0 = read).
- Reset: state IDLE, gnt_m = 0, gnt_w = 0, last_m = 1. All s_* requests 0; all m*_rvalid/m*_wvalid 0; all m*_rdata 0.
- IDLE:
  - s_ren = s_wen = 0.
  - If any m*_ren or m*_wen is high, pick a master, latch gnt_m and gnt_w, go to GRANT.
  - Within the chosen master, write wins over read.
- GRANT:
  - Drive s_* from the granted master's channel (live addr/data/mask).
  - Drive s_ren = gnt_w ? 0 : m_ren[gnt_m].
  - Drive s_wen = gnt_w ? m_wen[gnt_m] : 0.
  - Other channel and other master: s-side 0.
- Response:
  - m[gnt_m]_rvalid = s_rvalid & state==GRANT & ~gnt_w (combinational), and rdata likewise.
  - wvalid mirrors this for the write channel.
  - Non-granted master sees valid = 0 and rdata = 0.
- Completion: on the matching s_*valid, go to IDLE next edge and set last_m = gnt_m.
- Latency: request-to-memory adds exactly 1 cycle (IDLE arbitration cycle). Response path adds 0 cycles.
- Back-to-back: a master requesting again is not regranted before one IDLE cycle.
- Abort: if the granted master drops its request while in GRANT without a valid, go to IDLE next edge.
  - Covers cache-enable switch mid-flight.
  - s_ren/s_wen follow the master's live request, so they drop the same cycle.
- Stray valid: s_rvalid/s_wvalid in IDLE, or on the non-granted channel, is ignored and not forwarded.
- Reset mid-GRANT: state IDLE next edge, s requests 0. The memory is reset in the same cycle.
- A master holding both ren and wen is served write, then read, as separate grants.

Optional Feature:
MEM_PORT_ARB_RR_EN
- Defined: round-robin. In IDLE with both masters requesting, grant the master != last_m.
- Undefined: fixed priority, master 0 (dcache) always wins; last_m is still maintained but unused.

Decomposition:
- Package mem_port_arb_pkg holds:
  - the state enum typedef (IDLE, GRANT)
  - master index constants M_DCACHE = 0, M_ICACHE = 1
  - a grant struct {m, w}
- One natural sub-module, mem_port_arb_pick: combinational; inputs req[1:0], last_m; outputs the chosen master. The RR macro is confined here.

Test Plan:
- Single read: m0_ren = 1, raddr = 0x8000_0040; memory returns rvalid after 3 cycles with rdata = 0xDEAD..BEEF.
  - s_ren rises 1 cycle after m0_ren.
  - m0_rvalid pulses with that data.
  - m1_rvalid stays 0.
- Simultaneous: m0 and m1 both ren in the same cycle.
  - With RR_EN from reset: m0 is served first (last_m = 1), then m1.
  - Without RR_EN: repeated m0 requests starve m1.
- Write-over-read: m0_wen = 1 and m0_ren = 1 together, wmask = 0x00FF.
  - Write forwarded first; m0_wvalid pulses; then a separate read grant.
- Abort: m1_ren granted, m1 drops ren before rvalid.
  - s_ren drops the same cycle; state returns to IDLE next edge.
  - A late s_rvalid is not forwarded to either master.
- Reset mid-GRANT: rstn = 0 while a write is in flight.
  - Next edge: s_wen = 0, all valids 0, state IDLE.
  - After release, the first request is granted to m0.
- Stray s_rvalid in IDLE: no m*_rvalid pulse, state unchanged.

Source files
------------

// File: rtl/mem_port_arb_pkg.sv
// Shared types for the two-master memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arb_pkg;

    // Arbiter FSM: IDLE arbitrates, GRANT forwards one transaction.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Master indices.
    localparam logic M_DCACHE = 1'b0;
    localparam logic M_ICACHE = 1'b1;

    // Latched grant: which master, and which channel (1 = write, 0 = read).
    typedef struct packed {
        logic m;
        logic w;
    } grant_t;

endpackage

// File: rtl/mem_port_arb_pick.sv
// Chooses which master to grant when arbitration runs.
// Latency: combinational.
// Backpressure: none; the caller only samples pick while some req bit is high.
// Ports: req[1:0] per-master request (read or write), last_m master served most
// recently, pick chosen master index.
// Build option: MEM_PORT_ARB_RR_EN selects round-robin; otherwise dcache
// has fixed priority and last_m is ignored.
module mem_port_arb_pick
    import mem_port_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_m,
    output logic       pick
);

`ifdef MEM_PORT_ARB_RR_EN
    // On a tie, hand the port to whoever was not served last.
    always_comb begin
        pick = M_DCACHE;
        if (&req)
            pick = ~last_m;
        else if (req[M_ICACHE])
            pick = M_ICACHE;
    end
`else
    // Dcache always wins; icache only gets the port when dcache is quiet.
    always_comb begin
        pick = M_DCACHE;
        if (!req[M_DCACHE] && req[M_ICACHE])
            pick = M_ICACHE;
    end

    logic unused_last_m;
    assign unused_last_m = last_m;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges dcache (m0) and icache (m1) memory request ports onto one memory port.
// Latency: one arbitration cycle request-to-memory; response path is combinational.
// Backpressure: one transaction at a time; masters hold ren/wen until their done pulse.
// Ports: m{0,1}_* master read/write channels (ren/wen held until rvalid/wvalid),
// s_* single memory-side port. Sync active-low reset rstn on clk.
// Build option: MEM_PORT_ARB_RR_EN (round-robin tie-break, see mem_port_arb_pick).
module mem_port_arbiter
    import mem_port_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    // master 0: dcache
    input  logic [ADDR_WIDTH-1:0] m0_raddr,
    input  logic                  m0_ren,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic [ADDR_WIDTH-1:0] m0_waddr,
    input  logic                  m0_wen,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [MASK_WIDTH-1:0] m0_wmask,
    output logic                  m0_wvalid,
    // master 1: icache
    input  logic [ADDR_WIDTH-1:0] m1_raddr,
    input  logic                  m1_ren,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    input  logic [ADDR_WIDTH-1:0] m1_waddr,
    input  logic                  m1_wen,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [MASK_WIDTH-1:0] m1_wmask,
    output logic                  m1_wvalid,
    // memory side
    output logic [ADDR_WIDTH-1:0] s_raddr,
    output logic                  s_ren,
    output logic [ADDR_WIDTH-1:0] s_waddr,
    output logic                  s_wen,
    output logic [DATA_WIDTH-1:0] s_wdata,
    output logic [MASK_WIDTH-1:0] s_wmask,
    input  logic                  s_rvalid,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic                  s_wvalid
);

    state_t state;
    grant_t gnt;
    logic   last_m;
    logic   pick;

    logic [1:0]            ren;
    logic [1:0]            wen;
    logic [1:0]            req;
    logic [ADDR_WIDTH-1:0] raddr [2];
    logic [ADDR_WIDTH-1:0] waddr [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [MASK_WIDTH-1:0] wmask [2];

    assign ren      = {m1_ren, m0_ren};
    assign wen      = {m1_wen, m0_wen};
    assign req      = ren | wen;
    assign raddr[0] = m0_raddr;
    assign raddr[1] = m1_raddr;
    assign waddr[0] = m0_waddr;
    assign waddr[1] = m1_waddr;
    assign wdata[0] = m0_wdata;
    assign wdata[1] = m1_wdata;
    assign wmask[0] = m0_wmask;
    assign wmask[1] = m1_wmask;

    mem_port_arb_pick u_pick (
        .req    (req),
        .last_m (last_m),
        .pick   (pick)
    );

    logic rd_act;
    logic wr_act;
    logic cur_req;
    logic done;
    logic rd_done;
    logic wr_done;

    assign rd_act  = (state == GRANT) && !gnt.w;
    assign wr_act  = (state == GRANT) &&  gnt.w;
    // Live request of the granted channel; dropping it mid-flight aborts.
    assign cur_req = gnt.w ? wen[gnt.m] : ren[gnt.m];
    // Valids on the channel we did not grant are strays and are dropped.
    assign rd_done = rd_act && s_rvalid;
    assign wr_done = wr_act && s_wvalid;
    assign done    = rd_done || wr_done;

    // Memory-side request follows the granted master live, so an abort
    // removes it in the same cycle.
    assign s_ren   = rd_act && ren[gnt.m];
    assign s_raddr = rd_act ? raddr[gnt.m] : '0;
    assign s_wen   = wr_act && wen[gnt.m];
    assign s_waddr = wr_act ? waddr[gnt.m] : '0;
    assign s_wdata = wr_act ? wdata[gnt.m] : '0;
    assign s_wmask = wr_act ? wmask[gnt.m] : '0;

    // Responses go straight back to the granted master only.
    assign m0_rvalid = rd_done && (gnt.m == M_DCACHE);
    assign m1_rvalid = rd_done && (gnt.m == M_ICACHE);
    assign m0_wvalid = wr_done && (gnt.m == M_DCACHE);
    assign m1_wvalid = wr_done && (gnt.m == M_ICACHE);
    assign m0_rdata  = m0_rvalid ? s_rdata : '0;
    assign m1_rdata  = m1_rvalid ? s_rdata : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            gnt    <= '0;
            last_m <= M_ICACHE;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt.m <= pick;
                        // Write beats read within the chosen master.
                        gnt.w <= wen[pick];
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (done) begin
                        state  <= IDLE;
                        last_m <= gnt.m;
                    end else if (!cur_req) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
